mem_ctrl: RTL and testbench

- Memory controller: the initiator side of the byte-wide synchronous on-board RAM.
- Serves two clients, instruction fetch (IF) and load/store (LS). Breaks each 1/2/4-byte request into sequential single-byte RAM accesses.
- Assembles read bytes little-endian and returns them with a one-cycle done pulse.
- Sits between the CPU core and the RAM instance.

---
 rtl/mem_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: initiator side of the byte-wide synchronous on-board RAM.
// Serves instruction fetch (IF, always 4 bytes) and load/store (LS, 1/2/4
// bytes). Each request becomes sequential single-byte RAM accesses. Read bytes
// are assembled little-endian and returned with a one-cycle done pulse.
// RAM-side outputs are registered from next-state values, so they line up with
// the state they belong to and never glitch.
module mem_ctrl #(
    parameter int ADDR_WIDTH = 17
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  flush_in,
    input  logic                  if_valid_in,
    input  logic [31:0]           if_addr_in,
    output logic                  if_done_out,
    output logic [31:0]           if_data_out,
    input  logic                  ls_valid_in,
    input  logic                  ls_wr_in,
    input  logic [1:0]            ls_size_in,
    input  logic [31:0]           ls_addr_in,
    input  logic [31:0]           ls_data_in,
    output logic                  ls_done_out,
    output logic [31:0]           ls_data_out,
    output logic                  ram_en_out,
    output logic                  ram_r_nw_out,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_d_out,
    input  logic [7:0]            ram_d_in
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            cnt_q, cnt_d;
    logic [2:0]            n_q, n_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  own_if_q, own_if_d;
    logic [31:0]           asm_q, asm_d;
    logic                  if_done_q, if_done_d;
    logic [31:0]           if_data_q, if_data_d;
    logic                  ls_done_q, ls_done_d;
    logic [31:0]           ls_data_q, ls_data_d;
    logic                  ram_en_q, ram_en_d;
    logic                  ram_r_nw_q, ram_r_nw_d;
    logic [ADDR_WIDTH-1:0] ram_a_q, ram_a_d;
    logic [7:0]            ram_d_q, ram_d_d;
    logic [1:0]            lane_s;

    // Upper client address bits are intentionally ignored.
    logic unused_s;
    assign unused_s = ^{if_addr_in[31:ADDR_WIDTH], ls_addr_in[31:ADDR_WIDTH]};

    // Size code to byte count; the reserved code 11 behaves as a word.
    function automatic logic [2:0] size_to_n(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            2'b00:   n = 3'd1;
            2'b01:   n = 3'd2;
            2'b10:   n = 3'd4;
            default: n = 3'd4;
        endcase
        return n;
    endfunction

    // Select little-endian byte lane idx of a word.
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    // Replace little-endian byte lane idx of a word.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    // Byte arriving while at count cnt belongs to lane cnt-1 (RAM read latency of one).
    assign lane_s = cnt_q[1:0] - 2'd1;

    // State register: all sequential state, synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            n_q        <= 3'd0;
            base_q     <= '0;
            wdata_q    <= 32'd0;
            own_if_q   <= 1'b0;
            asm_q      <= 32'd0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_data_q  <= 32'd0;
            ram_en_q   <= 1'b0;
            ram_r_nw_q <= 1'b1;
            ram_a_q    <= '0;
            ram_d_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            own_if_q   <= own_if_d;
            asm_q      <= asm_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_data_q  <= ls_data_d;
            ram_en_q   <= ram_en_d;
            ram_r_nw_q <= ram_r_nw_d;
            ram_a_q    <= ram_a_d;
            ram_d_q    <= ram_d_d;
        end
    end

    // Next-state logic: request acceptance, byte sequencing, read assembly and completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        base_d    = base_q;
        wdata_d   = wdata_q;
        own_if_d  = own_if_q;
        asm_d     = asm_q;
        if_done_d = 1'b0;
        if_data_d = if_data_q;
        ls_done_d = 1'b0;
        ls_data_d = ls_data_q;
        case (state_q)
            ST_IDLE: begin
                if (if_done_q || ls_done_q) begin
                    // Dead cycle: clients still hold the just-completed request.
                    state_d = ST_IDLE;
                end else if (ls_valid_in) begin
                    base_d   = ls_addr_in[ADDR_WIDTH-1:0];
                    n_d      = size_to_n(ls_size_in);
                    wdata_d  = ls_data_in;
                    own_if_d = 1'b0;
                    cnt_d    = 3'd0;
                    asm_d    = 32'd0;
                    state_d  = ls_wr_in ? ST_WRITE : ST_READ;
                end else if (if_valid_in && !flush_in) begin
                    base_d   = if_addr_in[ADDR_WIDTH-1:0];
                    n_d      = 3'd4;
                    own_if_d = 1'b1;
                    cnt_d    = 3'd0;
                    asm_d    = 32'd0;
                    state_d  = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (own_if_q && flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    if (cnt_q != 3'd0) begin
                        asm_d = put_byte(asm_q, lane_s, ram_d_in);
                    end else begin
                        asm_d = asm_q;
                    end
                    if (cnt_q == n_q) begin
                        state_d = ST_IDLE;
                        if (own_if_q) begin
                            if_done_d = 1'b1;
                            if_data_d = asm_d;
                        end else begin
                            ls_done_d = 1'b1;
                            ls_data_d = asm_d;
                        end
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            ST_WRITE: begin
                if (cnt_q == n_q - 3'd1) begin
                    ls_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode: RAM strobes for the upcoming cycle, derived from next-state values.
    always_comb begin
        ram_en_d   = 1'b0;
        ram_r_nw_d = 1'b1;
        ram_a_d    = ram_a_q;
        ram_d_d    = ram_d_q;
        if (state_d == ST_READ && cnt_d < n_d) begin
            ram_en_d = 1'b1;
            ram_a_d  = base_d + {{(ADDR_WIDTH-3){1'b0}}, cnt_d};
        end else if (state_d == ST_WRITE && cnt_d < n_d) begin
            ram_en_d   = 1'b1;
            ram_r_nw_d = 1'b0;
            ram_a_d    = base_d + {{(ADDR_WIDTH-3){1'b0}}, cnt_d};
            ram_d_d    = get_byte(wdata_d, cnt_d[1:0]);
        end else begin
            ram_en_d   = 1'b0;
            ram_r_nw_d = 1'b1;
        end
    end

    assign if_done_out  = if_done_q;
    assign if_data_out  = if_data_q;
    assign ls_done_out  = ls_done_q;
    assign ls_data_out  = ls_data_q;
    assign ram_en_out   = ram_en_q;
    assign ram_r_nw_out = ram_r_nw_q;
    assign ram_a_out    = ram_a_q;
    assign ram_d_out    = ram_d_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl. A transaction-level model turns
// each request into a per-cycle expectation table (RAM strobes, done pulses,
// data outputs) using the request/access/done timing rules; one compare
// process checks every cycle against it. A bench RAM answers reads.
module tb_mem_ctrl;

    localparam int AW   = 17;
    localparam int MSZ  = 1 << AW;
    localparam int MAXC = 128;
    localparam int NOCUT = 100000;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          flush_in = 1'b0;
    logic          if_valid_in = 1'b0;
    logic [31:0]   if_addr_in = 32'd0;
    logic          if_done_out;
    logic [31:0]   if_data_out;
    logic          ls_valid_in = 1'b0;
    logic          ls_wr_in = 1'b0;
    logic [1:0]    ls_size_in = 2'd0;
    logic [31:0]   ls_addr_in = 32'd0;
    logic [31:0]   ls_data_in = 32'd0;
    logic          ls_done_out;
    logic [31:0]   ls_data_out;
    logic          ram_en_out;
    logic          ram_r_nw_out;
    logic [AW-1:0] ram_a_out;
    logic [7:0]    ram_d_out;
    logic [7:0]    ram_d_in = 8'd0;

    mem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in),
        .if_valid_in(if_valid_in), .if_addr_in(if_addr_in),
        .if_done_out(if_done_out), .if_data_out(if_data_out),
        .ls_valid_in(ls_valid_in), .ls_wr_in(ls_wr_in), .ls_size_in(ls_size_in),
        .ls_addr_in(ls_addr_in), .ls_data_in(ls_data_in),
        .ls_done_out(ls_done_out), .ls_data_out(ls_data_out),
        .ram_en_out(ram_en_out), .ram_r_nw_out(ram_r_nw_out),
        .ram_a_out(ram_a_out), .ram_d_out(ram_d_out), .ram_d_in(ram_d_in)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    // Cycle k is the interval following the k-th rising edge.
    always @(posedge clk_in) cyc <= cyc + 1;

    // Bench RAM and golden copy.
    logic [7:0] mem  [0:MSZ-1];
    logic [7:0] gold [0:MSZ-1];
    bit pre_done = 1'b0;

    function automatic logic [7:0] preload_val(input int a);
        case (a)
            32'h100:   return 8'h11;
            32'h101:   return 8'h22;
            32'h102:   return 8'h33;
            32'h103:   return 8'h44;
            32'h1FFFE: return 8'h55;
            32'h1FFFF: return 8'h66;
            32'h00000: return 8'h77;
            32'h00001: return 8'h88;
            default:   return 8'h00;
        endcase
    endfunction

    // Synchronous byte RAM: read data appears the cycle after the address.
    always @(posedge clk_in) begin
        if (!pre_done) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= preload_val(i);
            pre_done <= 1'b1;
        end else if (ram_en_out) begin
            if (ram_r_nw_out) ram_d_in <= mem[ram_a_out];
            else mem[ram_a_out] <= ram_d_out;
        end
    end

    // Per-cycle expectation table.
    bit          exp_en   [0:MAXC-1];
    bit          exp_rnw  [0:MAXC-1];
    bit          chk_a    [0:MAXC-1];
    bit          chk_d    [0:MAXC-1];
    logic [31:0] exp_a    [0:MAXC-1];
    logic [7:0]  exp_d    [0:MAXC-1];
    bit          exp_ifd  [0:MAXC-1];
    bit          exp_lsd  [0:MAXC-1];
    bit          upd_if   [0:MAXC-1];
    bit          upd_ls   [0:MAXC-1];
    logic [31:0] val_if   [0:MAXC-1];
    logic [31:0] val_ls   [0:MAXC-1];
    logic [31:0] cur_if = 32'd0;
    logic [31:0] cur_ls = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
        end
    endtask

    // Model one request accepted at the edge ending cycle c0. Accesses fall in
    // cycles c0+1..c0+n; a read is done in c0+n+2, a write in c0+n+1. Anything
    // scheduled after cycle 'cut' (flush/reset) never happens.
    task automatic sched(input bit is_if, input bit wr, input int n, input logic [31:0] addr,
                         input logic [31:0] wd, input int c0, input int cut);
        logic [31:0] rd;
        int t, a, dt;
        rd = 32'd0;
        for (int k = 0; k < n; k++) begin
            t = c0 + 1 + k;
            a = (addr + k) % MSZ;
            if (t <= cut) begin
                exp_en[t]  = 1'b1;
                exp_rnw[t] = !wr;
                chk_a[t]   = 1'b1;
                exp_a[t]   = a;
                if (wr) begin
                    exp_d[t] = (wd >> (8 * k)) & 32'hFF;
                    chk_d[t] = 1'b1;
                    gold[a]  = exp_d[t];
                end
            end
            rd = rd | ({24'd0, gold[a]} << (8 * k));
        end
        dt = wr ? c0 + n + 1 : c0 + n + 2;
        if (dt <= cut) begin
            if (is_if) begin
                exp_ifd[dt] = 1'b1;
                upd_if[dt]  = 1'b1;
                val_if[dt]  = rd;
            end else begin
                exp_lsd[dt] = 1'b1;
                if (!wr) begin
                    upd_ls[dt] = 1'b1;
                    val_ls[dt] = rd;
                end
            end
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    // Compare process: every cycle, DUT outputs against the expectation table.
    always @(negedge clk_in) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (upd_if[cyc]) cur_if = val_if[cyc];
            if (upd_ls[cyc]) cur_ls = val_ls[cyc];
            chk("ram_en", {31'd0, ram_en_out}, {31'd0, exp_en[cyc]});
            chk("ram_r_nw", {31'd0, ram_r_nw_out}, {31'd0, exp_rnw[cyc]});
            chk("if_done", {31'd0, if_done_out}, {31'd0, exp_ifd[cyc]});
            chk("ls_done", {31'd0, ls_done_out}, {31'd0, exp_lsd[cyc]});
            chk("if_data", if_data_out, cur_if);
            chk("ls_data", ls_data_out, cur_ls);
            if (chk_a[cyc]) chk("ram_a", {15'd0, ram_a_out}, exp_a[cyc]);
            if (chk_d[cyc]) chk("ram_d", {24'd0, ram_d_out}, {24'd0, exp_d[cyc]});
        end
    end

    task automatic ls_req(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wd);
        ls_valid_in = 1'b1;
        ls_wr_in    = wr;
        ls_size_in  = size;
        ls_addr_in  = addr;
        ls_data_in  = wd;
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_en[i] = 1'b0; exp_rnw[i] = 1'b1; chk_a[i] = 1'b0; chk_d[i] = 1'b0;
            exp_a[i] = 32'd0; exp_d[i] = 8'd0; exp_ifd[i] = 1'b0; exp_lsd[i] = 1'b0;
            upd_if[i] = 1'b0; upd_ls[i] = 1'b0; val_if[i] = 32'd0; val_ls[i] = 32'd0;
        end
        for (int i = 0; i < MSZ; i++) gold[i] = preload_val(i);
        // Reset values of address/data outputs.
        chk_a[1] = 1'b1; chk_d[1] = 1'b1;

        goto(2);
        rst_in = 1'b0;

        // IF word read at 0x100.
        sched(1'b1, 1'b0, 4, 32'h100, 32'd0, 3, NOCUT);
        goto(3);
        if_valid_in = 1'b1; if_addr_in = 32'h100;
        goto(10);
        if_valid_in = 1'b0;
        chk("t1_if_word", if_data_out, 32'h44332211);

        // Half store 0xAABBCCDD at 0x20, then byte load at 0x21.
        sched(1'b0, 1'b1, 2, 32'h20, 32'hAABBCCDD, 12, NOCUT);
        goto(12);
        ls_req(1'b1, 2'b01, 32'h20, 32'hAABBCCDD);
        goto(16);
        ls_valid_in = 1'b0;
        chk("t2_mem20", {24'd0, mem[17'h20]}, 32'hDD);
        chk("t2_mem21", {24'd0, mem[17'h21]}, 32'hCC);
        chk("t2_mem22", {24'd0, mem[17'h22]}, 32'h00);
        sched(1'b0, 1'b0, 1, 32'h21, 32'd0, 17, NOCUT);
        goto(17);
        ls_req(1'b0, 2'b00, 32'h21, 32'd0);
        goto(21);
        ls_valid_in = 1'b0;
        chk("t3_ls_byte", ls_data_out, 32'h000000CC);

        // IF and LS together: LS word store first, IF after the dead cycle.
        sched(1'b0, 1'b1, 4, 32'h40, 32'h01020304, 23, NOCUT);
        sched(1'b1, 1'b0, 4, 32'h100, 32'd0, 29, NOCUT);
        goto(23);
        ls_req(1'b1, 2'b10, 32'h40, 32'h01020304);
        if_valid_in = 1'b1; if_addr_in = 32'h100;
        goto(29);
        ls_valid_in = 1'b0;
        goto(36);
        if_valid_in = 1'b0;
        chk("t4_mem43", {24'd0, mem[17'h43]}, 32'h01);

        // IF read flushed in its third access cycle, then an LS word load
        // with a flush pulse that must not disturb it.
        sched(1'b1, 1'b0, 4, 32'h102, 32'd0, 38, 41);
        sched(1'b0, 1'b0, 4, 32'h100, 32'd0, 42, NOCUT);
        goto(38);
        if_valid_in = 1'b1; if_addr_in = 32'h102;
        goto(41);
        flush_in = 1'b1;
        goto(42);
        flush_in = 1'b0; if_valid_in = 1'b0;
        ls_req(1'b0, 2'b10, 32'h100, 32'd0);
        goto(44);
        flush_in = 1'b1;
        goto(45);
        flush_in = 1'b0;
        goto(49);
        ls_valid_in = 1'b0;
        chk("t5_if_kept", if_data_out, 32'h44332211);

        // Word load across the top of the address space, upper bits ignored.
        sched(1'b0, 1'b0, 4, 32'hFFF1FFFE, 32'd0, 51, NOCUT);
        goto(51);
        ls_req(1'b0, 2'b11, 32'hFFF1FFFE, 32'd0);
        goto(58);
        ls_valid_in = 1'b0;
        chk("t6_wrap", ls_data_out, 32'h88776655);

        // Reset during the second access cycle of a word store.
        sched(1'b0, 1'b1, 4, 32'h200, 32'hDEADBEEF, 60, 62);
        chk_a[63] = 1'b1; chk_d[63] = 1'b1;
        upd_if[63] = 1'b1; upd_ls[63] = 1'b1;
        goto(60);
        ls_req(1'b1, 2'b10, 32'h200, 32'hDEADBEEF);
        goto(62);
        rst_in = 1'b1;
        goto(63);
        rst_in = 1'b0; ls_valid_in = 1'b0;
        chk("t7_mem200", {24'd0, mem[17'h200]}, 32'hEF);
        chk("t7_mem202", {24'd0, mem[17'h202]}, 32'h00);
        chk("t7_mem203", {24'd0, mem[17'h203]}, 32'h00);

        // Normal IF read after reset, of the half stored earlier.
        sched(1'b1, 1'b0, 4, 32'h20, 32'd0, 65, NOCUT);
        goto(65);
        if_valid_in = 1'b1; if_addr_in = 32'h20;
        goto(72);
        if_valid_in = 1'b0;
        chk("t8_if_after_rst", if_data_out, 32'h0000CCDD);
        goto(76);

        for (int i = 0; i < 17'h300; i++) begin
            if (mem[i] !== gold[i]) begin
                chk("ram_image", {24'd0, mem[i]}, {24'd0, gold[i]});
            end
        end
        chk("ram_image_top", {24'd0, mem[17'h1FFFF]}, {24'd0, gold[17'h1FFFF]});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
